// File: rtl/arb_mux_rr.sv
// arb_mux_rr: registered NUM_CH:1 valid/ready mux, round-robin or fixed priority, packets never interleaved
module arb_mux_rr #(
  parameter int WIDTH = 32,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);
  typedef enum logic {ARB, LOCK} state_e;
  state_e state_q, state_d;
  logic [SEL_W-1:0] lk_q, lk_d, ptr_q, ptr_d, gsel, ch_q;
  logic [NUM_CH-1:0] grant;
  logic [WIDTH-1:0] data_q;
  logic gnt_any, load_en, acc, g_last, last_q, valid_q;

  function automatic logic [SEL_W-1:0] wrap(input int c);
    return SEL_W'(c >= NUM_CH ? c - NUM_CH : c);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      lk_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      lk_q <= lk_d;
      ptr_q <= ptr_d;
    end
  end

  // Descending scan so the last hit is the highest-priority candidate
  always_comb begin
    gsel = lk_q;
    gnt_any = in_valid[lk_q];
    if (state_q == ARB) begin
      gsel = '0;
      gnt_any = |in_valid;
      for (int k = NUM_CH - 1; k >= 0; k--)
        if (in_valid[wrap(mode ? k : int'(ptr_q) + k)]) gsel = wrap(mode ? k : int'(ptr_q) + k);
    end
  end

  always_comb begin
    state_d = state_q;
    lk_d = lk_q;
    ptr_d = ptr_q;
    if (acc) begin
      state_d = g_last ? ARB : LOCK;
      lk_d = gsel;
      if (g_last && !mode) ptr_d = (gsel == SEL_W'(NUM_CH - 1)) ? '0 : gsel + SEL_W'(1);
    end
  end

  always_comb begin
    load_en = !valid_q || out_ready;
    acc = gnt_any && load_en && !reset;
    grant = gnt_any ? NUM_CH'(1) << gsel : '0;
    in_ready = grant & {NUM_CH{load_en && !reset}};
    g_last = in_last[gsel];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      ch_q <= '0;
    end else if (acc) begin
      valid_q <= 1'b1;
      data_q <= in_data[int'(gsel)*WIDTH +: WIDTH];
      last_q <= g_last;
      ch_q <= gsel;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data = data_q;
  assign out_last = last_q;
  assign out_ch = ch_q;
  assign out_valid = valid_q;
endmodule
